// File: rtl/immediate_encode.sv
// immediate_encode
//   Two-stage elastic pipeline that packs an immediate value into the bit
//   positions it occupies in a 32-bit instruction word (instruction[31:7]).
//   This is the inverse of the immediate generator: for every value the
//   selected format can represent, generate(encode(x)) == x.
//
//   Stage S1 registers IMM/IMM_SEL. Stage S2 registers the packed OUT and ERR.
//
// Ports
//   CLK        in   1   clock, rising edge
//   RESET      in   1   asynchronous reset, active low
//   IN_VALID   in   1   request valid
//   IN_READY   out  1   request can be accepted this cycle
//   IMM        in  32   sign/zero-extended immediate to pack
//   IMM_SEL    in   3   000 U, 001 J, 010 B, 011 I, 100 IU, 101 S, 110 SFT,
//                       111 reserved
//   OUT        out 25   OUT[n] = instruction[n+7]; non-immediate bits are 0
//   OUT_VALID  out  1   OUT/ERR hold a result
//   OUT_READY  in   1   downstream accepts the result
//   ERR        out  1   IMM not representable in the selected format
//
// Configuration
//   IMM_RANGE_CHECK_EN  when defined, ERR flags immediates that the selected
//                       format cannot represent (and the reserved select).
//                       When undefined, ERR is tied to 0 and no check logic
//                       exists. OUT is identical in both builds: packing
//                       always uses the truncated bits.
//
// Handshake: a transfer happens at a rising edge where valid and ready are
// both 1. A producer holds valid and its payload stable until the transfer;
// ready may depend combinationally on the consumer side (IN_READY depends on
// OUT_READY), but valid never depends on ready.

module immediate_encode (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IMM,
  input  logic [2:0]  IMM_SEL,
  output logic [24:0] OUT,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        ERR
);

  localparam logic [2:0] SEL_U   = 3'b000;
  localparam logic [2:0] SEL_J   = 3'b001;
  localparam logic [2:0] SEL_B   = 3'b010;
  localparam logic [2:0] SEL_I   = 3'b011;
  localparam logic [2:0] SEL_IU  = 3'b100;
  localparam logic [2:0] SEL_S   = 3'b101;
  localparam logic [2:0] SEL_SFT = 3'b110;

  logic        s1_valid;
  logic [31:0] s1_imm;
  logic [2:0]  s1_sel;

  logic        s2_valid;
  logic [24:0] s2_out;

  logic        s2_adv;
  logic        in_ready;
  logic [24:0] pack;

  // S2 can take new data when it is empty or its result leaves this cycle.
  // S1 can take new data when it is empty or its content moves into S2.
  assign s2_adv   = !s2_valid || OUT_READY;
  assign in_ready = !s1_valid || s2_adv;

  // Place immediate bits at their instruction positions (OUT[n] = inst[n+7]).
  always_comb begin
    pack = '0;
    case (s1_sel)
      SEL_U:   pack = {s1_imm[31:12], 5'b0};
      SEL_J:   pack = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], 5'b0};
      SEL_B:   pack = {s1_imm[12], s1_imm[10:5], 13'b0, s1_imm[4:1], s1_imm[11]};
      SEL_I:   pack = {s1_imm[11:0], 13'b0};
      SEL_IU:  pack = {s1_imm[11:0], 13'b0};
      SEL_S:   pack = {s1_imm[11:5], 13'b0, s1_imm[4:0]};
      SEL_SFT: pack = {7'b0, s1_imm[4:0], 13'b0};
      default: pack = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s1_valid <= 1'b0;
      s1_imm   <= '0;
      s1_sel   <= '0;
      s2_valid <= 1'b0;
      s2_out   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= IN_VALID;
        if (IN_VALID) begin
          s1_imm <= IMM;
          s1_sel <= IMM_SEL;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_out <= pack;
        end
      end
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic range_err;
  logic s2_err;

  // A value is representable when the bits the format drops are either zero
  // (alignment / unsigned formats) or copies of the format's sign bit.
  always_comb begin
    range_err = 1'b0;
    case (s1_sel)
      SEL_U:   range_err = (s1_imm[11:0] != 12'b0);
      SEL_J:   range_err = s1_imm[0] || (s1_imm[31:21] != {11{s1_imm[20]}});
      SEL_B:   range_err = s1_imm[0] || (s1_imm[31:13] != {19{s1_imm[12]}});
      SEL_I:   range_err = (s1_imm[31:12] != {20{s1_imm[11]}});
      SEL_S:   range_err = (s1_imm[31:12] != {20{s1_imm[11]}});
      SEL_IU:  range_err = (s1_imm[31:12] != 20'b0);
      SEL_SFT: range_err = (s1_imm[31:5] != 27'b0);
      default: range_err = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s2_err <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      s2_err <= range_err;
    end
  end

  assign ERR = s2_err;
`else
  assign ERR = 1'b0;
`endif

  assign IN_READY  = in_ready;
  assign OUT       = s2_out;
  assign OUT_VALID = s2_valid;

endmodule

// File: tb/tb_immediate_encode.sv
// tb_immediate_encode
//   Bench for immediate_encode. Expected results come from a reference model
//   that describes each format as a table of "instruction bit n takes
//   immediate bit k" and a separate immediate generator (the inverse
//   decoder). Representability is judged as generate(encode(x)) == x.

module tb_immediate_encode;

  logic        CLK;
  logic        RESET;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IMM;
  logic [2:0]  IMM_SEL;
  logic [24:0] OUT;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        ERR;

  immediate_encode dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IMM       (IMM),
    .IMM_SEL   (IMM_SEL),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .ERR       (ERR)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  logic [25:0] exp_q[$];   // {err, out}
  logic [35:0] rt_q[$];    // {representable, sel, imm}
  int          n_checks;
  int          n_fail;
  logic        held_valid;
  logic [25:0] held_val;
  logic        obs_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Immediate bit that lands on OUT[n], or -1 when that bit is not immediate.
  function automatic int src_bit(input logic [2:0] sel, input int n);
    int s;
    s = -1;
    case (sel)
      3'd0: if (n >= 5) s = n + 7;
      3'd1: begin
        if (n == 24) s = 20;
        else if (n >= 14) s = n - 13;
        else if (n == 13) s = 11;
        else if (n >= 5) s = n + 7;
      end
      3'd2: begin
        if (n == 24) s = 12;
        else if (n >= 18) s = n - 13;
        else if (n >= 1 && n <= 4) s = n;
        else if (n == 0) s = 11;
      end
      3'd3, 3'd4: if (n >= 13) s = n - 13;
      3'd5: begin
        if (n >= 18) s = n - 13;
        else if (n <= 4) s = n;
      end
      3'd6: if (n >= 13 && n <= 17) s = n - 13;
      default: s = -1;
    endcase
    return s;
  endfunction

  function automatic logic [24:0] model_pack(input logic [31:0] imm, input logic [2:0] sel);
    logic [24:0] p;
    int s;
    p = '0;
    for (int n = 0; n < 25; n++) begin
      s = src_bit(sel, n);
      if (s >= 0) p[n] = imm[s];
    end
    return p;
  endfunction

  // Immediate generator: rebuild the sign/zero-extended value from OUT.
  function automatic logic [31:0] model_gen(input logic [24:0] o, input logic [2:0] sel);
    logic [31:0] v;
    v = '0;
    case (sel)
      3'd0: v = {o[24:5], 12'b0};
      3'd1: v = {{11{o[24]}}, o[24], o[12:5], o[13], o[23:14], 1'b0};
      3'd2: v = {{19{o[24]}}, o[24], o[0], o[23:18], o[4:1], 1'b0};
      3'd3: v = {{20{o[24]}}, o[24:13]};
      3'd4: v = {20'b0, o[24:13]};
      3'd5: v = {{20{o[24]}}, o[24:18], o[4:0]};
      3'd6: v = {27'b0, o[17:13]};
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic model_err(input logic [31:0] imm, input logic [2:0] sel);
`ifdef IMM_RANGE_CHECK_EN
    return (sel == 3'd7) || (model_gen(model_pack(imm, sel), sel) != imm);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver + monitor, one cycle ----------------
  // Inputs change on the falling edge; outputs are sampled 1 time unit later,
  // well before the next rising edge where the transfers happen.
  task automatic cycle(input logic iv, input logic [31:0] im, input logic [2:0] sl,
                       input logic ordy, output logic accepted);
    logic [25:0] e;
    logic [35:0] r;
    @(negedge CLK);
    IN_VALID  = iv;
    IMM       = im;
    IMM_SEL   = sl;
    OUT_READY = ordy;
    #1;
    obs_valid = OUT_VALID;
    if (held_valid) begin
      check("hold_valid", {31'b0, OUT_VALID}, 32'd1);
      check("hold_data", {6'b0, ERR, OUT}, {6'b0, held_val});
    end
    held_valid = 1'b0;
    if (OUT_VALID) begin
      if (OUT_READY) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          r = rt_q.pop_front();
          check("out", {7'b0, OUT}, {7'b0, e[24:0]});
          check("err", {31'b0, ERR}, {31'b0, e[25]});
          if (r[35]) check("roundtrip", model_gen(OUT, r[34:32]), r[31:0]);
        end
      end else begin
        held_valid = 1'b1;
        held_val   = {ERR, OUT};
      end
    end
    accepted = IN_VALID && IN_READY;
    if (accepted) begin
      exp_q.push_back({model_err(im, sl), model_pack(im, sl)});
      rt_q.push_back({(sl != 3'd7) && (model_gen(model_pack(im, sl), sl) == im), sl, im});
    end
  endtask

  task automatic drain();
    logic acc;
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      cycle(1'b0, 32'h0, 3'd0, 1'b1, acc);
      budget++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    rt_q.delete();
  endtask

  task automatic send_one(input logic [31:0] im, input logic [2:0] sl);
    logic acc;
    int budget;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 20) begin
      cycle(1'b1, im, sl, 1'b1, acc);
      budget++;
    end
    check("send_timeout", {31'b0, acc}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic acc;
    logic [31:0] x;
    logic [2:0] sl;
    int budget;

    n_checks   = 0;
    n_fail     = 0;
    held_valid = 1'b0;
    obs_valid  = 1'b0;
    RESET      = 1'b0;
    IN_VALID   = 1'b0;
    IMM        = '0;
    IMM_SEL    = '0;
    OUT_READY  = 1'b0;

    #2;
    check("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    check("rst_out", {7'b0, OUT}, 32'd0);
    check("rst_err", {31'b0, ERR}, 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("rst_in_ready", {31'b0, IN_READY}, 32'd1);

    // Latency: accepted at edge A, OUT_VALID seen after edge A+1.
    cycle(1'b1, 32'hB038_8000, 3'd0, 1'b1, acc);
    check("lat_accept", {31'b0, acc}, 32'd1);
    cycle(1'b0, 32'h0, 3'd0, 1'b1, acc);
    check("lat_s1_only", {31'b0, obs_valid}, 32'd0);
    cycle(1'b0, 32'h0, 3'd0, 1'b1, acc);
    check("lat_out_valid", {31'b0, obs_valid}, 32'd1);
    check("u_const", {7'b0, model_pack(32'hB038_8000, 3'd0)}, 32'h0160_7100);

    // Directed format examples.
    send_one(32'hFFF4_EC6E, 3'd1);
    send_one(32'h0000_0001, 3'd1);
    send_one(32'hFFFF_FA49, 3'd3);
    send_one(32'hFFFF_FA49, 3'd4);
    send_one(32'h0000_0009, 3'd6);
    send_one(32'hFFFF_F7FE, 3'd2);
    send_one(32'hFFFF_F805, 3'd5);
    send_one(32'h1234_5678, 3'd7);
    drain();

    // Backpressure: two accepted, third stalls while OUT_READY=0.
    cycle(1'b1, 32'h0000_1000, 3'd0, 1'b0, acc);
    check("bp_acc0", {31'b0, acc}, 32'd1);
    cycle(1'b1, 32'h0000_07FF, 3'd3, 1'b0, acc);
    check("bp_acc1", {31'b0, acc}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 32'h0000_001F, 3'd6, 1'b0, acc);
      check("bp_stall", {31'b0, acc}, 32'd0);
    end
    // Output and input transfer in the same cycle.
    cycle(1'b1, 32'h0000_001F, 3'd6, 1'b1, acc);
    check("bp_both", {31'b0, acc}, 32'd1);
    drain();

    // Reset with both stages full.
    cycle(1'b1, 32'hABCD_E000, 3'd0, 1'b0, acc);
    cycle(1'b1, 32'h0000_0123, 3'd3, 1'b0, acc);
    cycle(1'b0, 32'h0, 3'd0, 1'b0, acc);
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    check("mid_rst_out", {7'b0, OUT}, 32'd0);
    check("mid_rst_err", {31'b0, ERR}, 32'd0);
    exp_q.delete();
    rt_q.delete();
    held_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 32'h0, 3'd0, 1'b1, acc);
      check("no_stale", {31'b0, obs_valid}, 32'd0);
    end

    // Randomized: 1000 accepted requests per format, mostly representable.
    for (int f = 0; f < 8; f++) begin
      for (int t = 0; t < ((f == 7) ? 100 : 1000); t++) begin
        sl = f[2:0];
        x = $urandom;
        if ($urandom_range(3) != 0) x = model_gen(model_pack(x, sl), sl);
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 50) begin
          if ($urandom_range(4) == 0)
            cycle(1'b0, $urandom, 3'($urandom_range(7)), 1'($urandom_range(3) != 0), acc);
          else
            cycle(1'b1, x, sl, 1'($urandom_range(3) != 0), acc);
          budget++;
        end
        if (!acc) check("rand_timeout", 32'd0, 32'd1);
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
